mdma_80bx256_ram_rsp: RTL and testbench

Responder (slave) end of the 80-bit x 256-entry MDMA RAM interface: stores 80-bit words, services writes and pipelined reads, and reports single- and double-bit ECC status on every read. It sits below any MDMA block that drives the master side of the RAM interface, such as context and descriptor tables. It serves as the simulation and FPGA stand-in for the hardened ECC RAM. It supports a reset-time clear sweep and directed ECC error injection for verification.

---
 rtl/mdma_ram_rsp_pkg.sv | 20 ++
 rtl/mdma_80bx256_80bwe_ram_if.sv | 24 ++
 rtl/mdma_ram_rd_pipe.sv | 56 +++++
 rtl/mdma_80bx256_ram_rsp.sv | 110 +++++++++++
 tb/tb_mdma_80bx256_ram_rsp.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdma_ram_rsp_pkg.sv
// Shared constants and types for the MDMA 80b x 256 RAM responder.
// Imported by the interface users, the read pipe and the top.
package mdma_ram_rsp_pkg;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int DW    = 80;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_SBE  = 2'd1,
    TAG_DBE  = 2'd2
  } tag_t;

endpackage

// File: rtl/mdma_80bx256_80bwe_ram_if.sv
// Master/responder bundle of the 80b x 256 MDMA RAM port.
// The responder sees the request side as inputs.
interface mdma_80bx256_80bwe_ram_if;

  logic [7:0]  wadr;
  logic        wen;
  logic [79:0] wdat;
  logic        ren;
  logic [7:0]  radr;
  logic [79:0] rdat;
  logic        rsbe;
  logic        rdbe;

  modport s (
    input  wadr, wen, wdat, ren, radr,
    output rdat, rsbe, rdbe
  );

  modport m (
    output wadr, wen, wdat, ren, radr,
    input  rdat, rsbe, rdbe
  );

endinterface

// File: rtl/mdma_ram_rd_pipe.sv
// RD_LAT-deep delay line for read results; the last stage holds
// its data when no result arrives, flags pulse only on arrival.
module mdma_ram_rd_pipe
  import mdma_ram_rsp_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          v_i,
  input  logic [DW-1:0] dat_i,
  input  logic          sbe_i,
  input  logic          dbe_i,
  output logic [DW-1:0] dat_o,
  output logic          sbe_o,
  output logic          dbe_o,
  output logic          err_o
);

  logic [RD_LAT-1:0]         v_q;
  logic [RD_LAT-1:0]         s_q;
  logic [RD_LAT-1:0]         b_q;
  logic [RD_LAT-1:0][DW-1:0] d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      s_q <= '0;
      b_q <= '0;
      d_q <= '0;
    end else begin
      v_q[0] <= v_i;
      s_q[0] <= sbe_i;
      b_q[0] <= dbe_i;
      if (v_i) d_q[0] <= dat_i;
      for (int i = 1; i < RD_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        s_q[i] <= s_q[i-1];
        b_q[i] <= b_q[i-1];
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end
  end

  assign dat_o = d_q[RD_LAT-1];
  assign sbe_o = v_q[RD_LAT-1] & s_q[RD_LAT-1];
  assign dbe_o = v_q[RD_LAT-1] & b_q[RD_LAT-1];

  // err_o flags a result that lands on the outputs at the next edge
  if (RD_LAT == 1) begin : g_err1
    assign err_o = v_i & (sbe_i | dbe_i);
  end else begin : g_errn
    assign err_o = v_q[RD_LAT-2] & (s_q[RD_LAT-2] | b_q[RD_LAT-2]);
  end

endmodule

// File: rtl/mdma_80bx256_ram_rsp.sv
// Responder end of the 80b x 256 MDMA RAM: storage, clear sweep,
// error-tag injection and pipelined reads with ECC status.
module mdma_80bx256_ram_rsp
  import mdma_ram_rsp_pkg::*;
#(
  parameter int          RD_LAT        = 2,
  parameter bit          INIT_ON_RESET = 1'b1,
  parameter logic [79:0] INIT_VAL      = 80'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  mdma_80bx256_80bwe_ram_if.s  ram,
  input  logic                 inj_en,
  input  logic                 inj_dbe,
  input  logic [7:0]           inj_adr,
  output logic                 init_done,
  output logic [15:0]          err_cnt
);

  state_t         state_q;
  logic [AW-1:0]  sweep_q;
  logic           init_done_q;
  logic [15:0]    err_q;

  logic [DW-1:0]  mem_q [DEPTH];
  tag_t           tag_q [DEPTH];

  logic           run;
  logic           sweep_we;
  logic           wr_en;
  logic           inj_we;
  logic           rd_v;
  tag_t           rd_tag;
  logic [DW-1:0]  rd_dat;
  logic           err_arr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        INIT: begin
          if (INIT_ON_RESET) sweep_q <= sweep_q + 1'b1;
          if (!INIT_ON_RESET || sweep_q == AW'(DEPTH - 1)) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= INIT;
        end
      endcase
    end
  end

  assign run      = !rst && (state_q == RUN);
  assign sweep_we = !rst && (state_q == INIT) && INIT_ON_RESET;
  assign wr_en    = run && ram.wen;
  assign inj_we   = run && inj_en;

  // later assignments win: injection overrides the write's tag clear
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem_q[sweep_q] <= INIT_VAL;
      tag_q[sweep_q] <= TAG_NONE;
    end
    if (wr_en) begin
      mem_q[ram.wadr] <= ram.wdat;
      tag_q[ram.wadr] <= TAG_NONE;
    end
    if (inj_we) tag_q[inj_adr] <= inj_dbe ? TAG_DBE : TAG_SBE;
  end

  assign rd_v   = run && ram.ren;
  assign rd_tag = tag_q[ram.radr];
  assign rd_dat = mem_q[ram.radr]
                ^ {{(DW-1){1'b0}}, rd_tag == TAG_DBE};

  mdma_ram_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .v_i   (rd_v),
    .dat_i (rd_dat),
    .sbe_i (rd_tag == TAG_SBE),
    .dbe_i (rd_tag == TAG_DBE),
    .dat_o (ram.rdat),
    .sbe_o (ram.rsbe),
    .dbe_o (ram.rdbe),
    .err_o (err_arr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else if (err_arr && err_q != 16'hFFFF) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign init_done = init_done_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_mdma_80bx256_ram_rsp.sv
// Randomized bench for mdma_80bx256_ram_rsp against a queue-based model.
// Directed checks pin the sweep, latency, injection and reset cases.
module tb_mdma_80bx256_ram_rsp;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        inj_en;
  logic        inj_dbe;
  logic [7:0]  inj_adr;
  logic        init_done;
  logic [15:0] err_cnt;

  mdma_80bx256_80bwe_ram_if ram_if ();

  mdma_80bx256_ram_rsp #(
    .RD_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ram       (ram_if),
    .inj_en    (inj_en),
    .inj_dbe   (inj_dbe),
    .inj_adr   (inj_adr),
    .init_done (init_done),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;

  typedef struct {
    int          due;
    logic [79:0] d;
    logic        s;
    logic        b;
  } res_t;

  logic [79:0] m_mem [256];
  logic [1:0]  m_tag [256];
  res_t        q [$];
  int          ecyc      = 0;
  int          init_left = 256;
  bit          mvalid    = 1'b0;
  logic [79:0] exp_rdat;
  logic        exp_s;
  logic        exp_b;
  logic [15:0] exp_err;
  logic        exp_done;

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Effect of the coming clock edge, using the inputs as driven now.
  task automatic model_step();
    res_t r;
    int   idx;
    ecyc++;
    exp_s = 1'b0;
    exp_b = 1'b0;
    if (rst) begin
      init_left = 256;
      q.delete();
      exp_rdat = '0;
      exp_err  = '0;
      exp_done = 1'b0;
      mvalid   = 1'b1;
      return;
    end
    if (init_left > 0) begin
      idx = 256 - init_left;
      m_mem[idx] = 80'h0;
      m_tag[idx] = 2'd0;
      init_left--;
      exp_done = (init_left == 0);
    end else begin
      if (ram_if.ren) begin
        r.due = ecyc + LAT - 1;
        r.s   = (m_tag[ram_if.radr] == 2'd1);
        r.b   = (m_tag[ram_if.radr] == 2'd2);
        r.d   = m_mem[ram_if.radr] ^ {79'h0, r.b};
        q.push_back(r);
      end
      if (ram_if.wen) begin
        m_mem[ram_if.wadr] = ram_if.wdat;
        m_tag[ram_if.wadr] = 2'd0;
      end
      if (inj_en) m_tag[inj_adr] = inj_dbe ? 2'd2 : 2'd1;
    end
    if (q.size() > 0 && q[0].due == ecyc) begin
      r = q.pop_front();
      exp_rdat = r.d;
      exp_s    = r.s;
      exp_b    = r.b;
      if ((r.s || r.b) && exp_err != 16'hFFFF) exp_err++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mvalid) begin
        chk("init_done", {79'h0, init_done}, {79'h0, exp_done});
        chk("rdat", ram_if.rdat, exp_rdat);
        chk("rsbe", {79'h0, ram_if.rsbe}, {79'h0, exp_s});
        chk("rdbe", {79'h0, ram_if.rdbe}, {79'h0, exp_b});
        chk("err_cnt", {64'h0, err_cnt}, {64'h0, exp_err});
      end
      model_step();
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    ram_if.wen = 1'b0;
    ram_if.ren = 1'b0;
    inj_en     = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [79:0] d);
    ram_if.wen  = 1'b1;
    ram_if.wadr = a;
    ram_if.wdat = d;
    step();
    ram_if.wen  = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    ram_if.ren  = 1'b1;
    ram_if.radr = a;
    step();
    ram_if.ren  = 1'b0;
  endtask

  // Release reset and check init_done rises exactly 256 edges later.
  task automatic sweep(input string nm, input bit poke);
    rst = 1'b0;
    for (int i = 0; i < 255; i++) begin
      ram_if.ren  = poke;
      ram_if.radr = 8'(i);
      ram_if.wen  = poke;
      ram_if.wadr = 8'(i);
      ram_if.wdat = {80{1'b1}};
      step();
    end
    chk({nm, "_done_lo"}, {79'h0, init_done}, 80'h0);
    step();
    idle();
    chk({nm, "_done_hi"}, {79'h0, init_done}, 80'h1);
  endtask

  logic [95:0] rnd;

  initial begin
    rst = 1'b1;
    idle();
    ram_if.wadr = '0;
    ram_if.wdat = '0;
    ram_if.radr = '0;
    inj_dbe = 1'b0;
    inj_adr = '0;
    repeat (3) step();

    // reset sweep, with traffic offered during INIT
    sweep("sweep1", 1'b1);
    for (int i = 0; i < 256; i++) begin
      ram_if.ren  = 1'b1;
      ram_if.radr = 8'(i);
      step();
    end
    idle();
    repeat (LAT) step();
    chk("sweep_rdat", ram_if.rdat, 80'h0);
    chk("sweep_err", {64'h0, err_cnt}, 80'h0);

    // write then read on the next cycle
    wr(8'h10, 80'hA5A5_0000_1234_5678_9ABC);
    rd(8'h10);
    repeat (LAT - 1) step();
    chk("lat_rdat", ram_if.rdat, 80'hA5A5_0000_1234_5678_9ABC);
    chk("lat_model", exp_rdat, 80'hA5A5_0000_1234_5678_9ABC);
    chk("lat_flags", {78'h0, ram_if.rsbe, ram_if.rdbe}, 80'h0);

    // single-bit injection, then cleared by rewrite
    wr(8'h20, 80'h1);
    inj_en = 1'b1; inj_dbe = 1'b0; inj_adr = 8'h20;
    step();
    inj_en = 1'b0;
    rd(8'h20);
    repeat (LAT - 1) step();
    chk("sbe_rdat", ram_if.rdat, 80'h1);
    chk("sbe_flags", {78'h0, ram_if.rsbe, ram_if.rdbe}, 80'h2);
    chk("sbe_err", {64'h0, err_cnt}, 80'h1);
    wr(8'h20, 80'h1);
    rd(8'h20);
    repeat (LAT - 1) step();
    chk("sbe_clr_flags", {78'h0, ram_if.rsbe, ram_if.rdbe}, 80'h0);

    // inject + write + read on one address in one cycle
    wr(8'h30, 80'h4);
    inj_en = 1'b1; inj_dbe = 1'b1; inj_adr = 8'h30;
    ram_if.wen = 1'b1; ram_if.wadr = 8'h30; ram_if.wdat = 80'h6;
    ram_if.ren = 1'b1; ram_if.radr = 8'h30;
    step();
    idle();
    rd(8'h30);
    repeat (LAT - 2) step();
    chk("col_rdat", ram_if.rdat, 80'h4);
    chk("col_flags", {78'h0, ram_if.rsbe, ram_if.rdbe}, 80'h0);
    step();
    chk("dbe_rdat", ram_if.rdat, 80'h7);
    chk("dbe_model", exp_rdat, 80'h7);
    chk("dbe_flags", {78'h0, ram_if.rsbe, ram_if.rdbe}, 80'h1);
    chk("dbe_err", {64'h0, err_cnt}, 80'h2);

    // reset with reads in flight, then an interrupted sweep
    wr(8'h00, 80'hBEEF);
    wr(8'h05, 80'hCAFE);
    inj_en = 1'b1; inj_dbe = 1'b1; inj_adr = 8'h05;
    step();
    idle();
    for (int i = 0; i < 4; i++) begin
      ram_if.ren  = 1'b1;
      ram_if.radr = (i % 2 == 0) ? 8'h00 : 8'h05;
      step();
    end
    idle();
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_rdat", ram_if.rdat, 80'h0);
    rst = 1'b0;
    repeat (10) step();
    chk("mid_rst_flags", {78'h0, ram_if.rsbe, ram_if.rdbe}, 80'h0);
    chk("mid_rst_rdat2", ram_if.rdat, 80'h0);
    rst = 1'b1;
    step();
    sweep("sweep2", 1'b0);
    rd(8'h05);
    repeat (LAT - 1) step();
    chk("sweep2_flags", {78'h0, ram_if.rsbe, ram_if.rdbe}, 80'h0);
    rd(8'h00);
    repeat (LAT - 1) step();
    chk("sweep2_rdat", ram_if.rdat, 80'h0);

    // random traffic, mostly on a small window to force hits
    for (int i = 0; i < 2000; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      ram_if.wen  = rnd[0];
      ram_if.ren  = rnd[1] | rnd[2];
      inj_en      = (rnd[5:3] == 3'd0);
      inj_dbe     = rnd[6];
      ram_if.wadr = rnd[7] ? rnd[15:8] : {4'h0, rnd[11:8]};
      ram_if.radr = rnd[7] ? rnd[23:16] : {4'h0, rnd[19:16]};
      inj_adr     = {4'h0, rnd[27:24]};
      rnd = {$urandom, $urandom, $urandom};
      ram_if.wdat = rnd[79:0];
      step();
    end
    idle();
    repeat (LAT + 2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
